// File: rtl/sdrd_capture.sv
// Serial-ID byte assembler: samples SDRD once per qualified bus read and builds bytes LSB-first.
// Flags: rdy when a byte is waiting, ovr on an unread overwrite, terr when a stalled partial byte is dropped.
module sdrd_capture #(
   parameter int SAMPLE_DLY = 2,
   parameter int TIMEOUT    = 1023
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       SSER,
   input  logic       BA13,
   input  logic       BA12,
   input  logic [3:0] BA,
   input  logic       BR_W,
   input  logic       SDRD,
   input  logic       rd_stb,
   output logic [7:0] data,
   output logic       rdy,
   output logic       ovr,
   output logic       terr,
   output logic [2:0] bitcnt
);

   // state  | meaning
   // IDLE   | waiting for a qualified access edge
   // DELAY  | counting down to the SDRD sample point
   // SAMPLE | one clk: capture SDRD, or clear on a resync access
   // HOLD   | access still active; wait for qual to drop
   typedef enum logic [1:0] {IDLE, DELAY, SAMPLE, HOLD} state_t;

   localparam logic [3:0] DLY_LOAD = 4'(SAMPLE_DLY - 1);
   localparam logic [9:0] TO_LAST  = 10'(TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [3:0] dly_q, dly_d;
   logic [9:0] idle_cnt_q, idle_cnt_d;
   logic [7:0] sh_q, sh_d;
   logic [7:0] data_q, data_d;
   logic [2:0] bitcnt_q, bitcnt_d;
   logic       rdy_q, rdy_d, ovr_q, ovr_d, terr_q, terr_d, qual_r_q, qual_r_d;

   logic qual, acc_edge, resync, do_sample, capture, complete, timeout_hit;

   always_comb begin
      qual        = ~SSER & ~BA13 & BA12 & BR_W;
      acc_edge    = qual & ~qual_r_q;
      resync      = (BA == 4'hF);
      do_sample   = (state_q == SAMPLE) & ~SSER;
      capture     = do_sample & ~resync;
      complete    = capture & (bitcnt_q == 3'd7);
      timeout_hit = (state_q == IDLE) & (bitcnt_q != 3'd0) & ~acc_edge & (idle_cnt_q == TO_LAST);

      state_d    = state_q;
      dly_d      = dly_q;
      idle_cnt_d = idle_cnt_q;
      sh_d       = sh_q;
      data_d     = data_q;
      bitcnt_d   = bitcnt_q;
      rdy_d      = rdy_q;
      ovr_d      = ovr_q;
      terr_d     = terr_q;
      qual_r_d   = qual;

      case (state_q)
         IDLE: if (acc_edge) begin
            state_d = DELAY;
            dly_d   = DLY_LOAD;
         end
         DELAY: begin
            if (!qual)                state_d = IDLE;
            else if (dly_q == 4'd0)   state_d = SAMPLE;
            else                      dly_d   = dly_q - 4'd1;
         end
         SAMPLE:  state_d = HOLD;
         HOLD:    if (!qual) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (SSER) state_d = IDLE;

      if (do_sample && resync) begin
         sh_d     = 8'h00;
         bitcnt_d = 3'd0;
      end else if (capture) begin
         if (complete) begin
            data_d   = {SDRD, sh_q[6:0]};
            sh_d     = 8'h00;
            bitcnt_d = 3'd0;
         end else begin
            sh_d[bitcnt_q] = SDRD;
            bitcnt_d       = bitcnt_q + 3'd1;
         end
      end

      if (acc_edge || bitcnt_q == 3'd0) begin
         idle_cnt_d = 10'd0;
      end else if (timeout_hit) begin
         idle_cnt_d = 10'd0;
         bitcnt_d   = 3'd0;
         sh_d       = 8'h00;
      end else if (state_q == IDLE && idle_cnt_q != 10'h3FF) begin
         idle_cnt_d = idle_cnt_q + 10'd1;
      end

      if (complete)    rdy_d = 1'b1;
      else if (rd_stb) rdy_d = 1'b0;

      // A read landing with the new byte consumes the old one, so no overrun.
      if (complete && rd_stb)     ovr_d = ovr_q;
      else if (complete && rdy_q) ovr_d = 1'b1;
      else if (rd_stb)            ovr_d = 1'b0;

      if (timeout_hit) terr_d = 1'b1;
      else if (rd_stb) terr_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         dly_q      <= 4'd0;
         idle_cnt_q <= 10'd0;
         sh_q       <= 8'h00;
         data_q     <= 8'h00;
         bitcnt_q   <= 3'd0;
         rdy_q      <= 1'b0;
         ovr_q      <= 1'b0;
         terr_q     <= 1'b0;
         qual_r_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         dly_q      <= dly_d;
         idle_cnt_q <= idle_cnt_d;
         sh_q       <= sh_d;
         data_q     <= data_d;
         bitcnt_q   <= bitcnt_d;
         rdy_q      <= rdy_d;
         ovr_q      <= ovr_d;
         terr_q     <= terr_d;
         qual_r_q   <= qual_r_d;
      end
   end

   assign data   = data_q;
   assign rdy    = rdy_q;
   assign ovr    = ovr_q;
   assign terr   = terr_q;
   assign bitcnt = bitcnt_q;

endmodule

// File: tb/tb_sdrd_capture.sv
// Directed bench for sdrd_capture: byte assembly, overrun, timeout, short access, resync, reset.
module tb_sdrd_capture;

   logic       clk = 1'b0;
   logic       rst, SSER, BA13, BA12, BR_W, SDRD, rd_stb;
   logic [3:0] BA;
   logic [7:0] data;
   logic       rdy, ovr, terr;
   logic [2:0] bitcnt;

   int n_tests = 0;
   int n_fail  = 0;

   sdrd_capture #(.SAMPLE_DLY(2), .TIMEOUT(1023)) dut (
      .clk(clk), .rst(rst), .SSER(SSER), .BA13(BA13), .BA12(BA12), .BA(BA),
      .BR_W(BR_W), .SDRD(SDRD), .rd_stb(rd_stb),
      .data(data), .rdy(rdy), .ovr(ovr), .terr(terr), .bitcnt(bitcnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One qualified access: qual high for 5 clks, then low for 3 clks.
   task automatic access(input logic b, input logic [3:0] ba);
      SSER = 1'b0; BA13 = 1'b0; BA12 = 1'b1; BR_W = 1'b1; BA = ba; SDRD = b;
      repeat (5) @(negedge clk);
      SSER = 1'b1; SDRD = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 0; i < 8; i++) access(b[i], 4'h0);
   endtask

   task automatic read_pulse();
      rd_stb = 1'b1;
      @(negedge clk);
      rd_stb = 1'b0;
   endtask

   initial begin
      rst = 1'b1; SSER = 1'b1; BA13 = 1'b0; BA12 = 1'b0; BR_W = 1'b0;
      BA = 4'h0; SDRD = 1'b0; rd_stb = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_data", data, 8'h00);
      chk("rst_rdy", rdy, 0);
      chk("rst_ovr", ovr, 0);
      chk("rst_terr", terr, 0);
      chk("rst_bitcnt", bitcnt, 0);

      // 8'hA5 sent as 1,0,1,0,0,1,0,1
      access(1'b1, 4'h0); access(1'b0, 4'h0); access(1'b1, 4'h0);
      chk("a5_partial_bitcnt", bitcnt, 3);
      chk("a5_partial_rdy", rdy, 0);
      access(1'b0, 4'h0); access(1'b0, 4'h0); access(1'b1, 4'h0);
      access(1'b0, 4'h0); access(1'b1, 4'h0);
      chk("a5_data", data, 8'hA5);
      chk("a5_rdy", rdy, 1);
      chk("a5_bitcnt", bitcnt, 0);
      chk("a5_ovr", ovr, 0);
      read_pulse();
      chk("a5_read_rdy", rdy, 0);

      send_byte(8'h3C);
      chk("3c_data", data, 8'h3C);
      chk("3c_ovr", ovr, 0);
      send_byte(8'hC3);
      chk("c3_data", data, 8'hC3);
      chk("c3_rdy", rdy, 1);
      chk("c3_ovr", ovr, 1);
      read_pulse();
      chk("c3_read_rdy", rdy, 0);
      chk("c3_read_ovr", ovr, 0);

      // Access too short to reach the sample point
      access(1'b1, 4'h0);
      SSER = 1'b0; BA13 = 1'b0; BA12 = 1'b1; BR_W = 1'b1; SDRD = 1'b1;
      @(negedge clk);
      SSER = 1'b1;
      repeat (3) @(negedge clk);
      chk("short_bitcnt", bitcnt, 1);

      access(1'b0, 4'h0); access(1'b1, 4'h0);
      chk("to_bitcnt3", bitcnt, 3);
      repeat (1000) @(negedge clk);
      chk("to_early_terr", terr, 0);
      chk("to_early_bitcnt", bitcnt, 3);
      repeat (40) @(negedge clk);
      chk("to_terr", terr, 1);
      chk("to_bitcnt", bitcnt, 0);
      send_byte(8'h5A);
      chk("5a_data", data, 8'h5A);
      chk("5a_rdy", rdy, 1);
      read_pulse();
      chk("5a_read_terr", terr, 0);
      chk("5a_read_rdy", rdy, 0);

      access(1'b1, 4'h0); access(1'b1, 4'h0);
      chk("rs_pre_bitcnt", bitcnt, 2);
      access(1'b1, 4'hF);
      chk("rs_bitcnt", bitcnt, 0);
      chk("rs_data_kept", data, 8'h5A);
      chk("rs_rdy_kept", rdy, 0);
      send_byte(8'h81);
      chk("81_data", data, 8'h81);
      chk("81_rdy", rdy, 1);

      // Reset while the 5th bit is in DELAY
      for (int i = 0; i < 4; i++) access(1'b1, 4'h0);
      SSER = 1'b0; BA13 = 1'b0; BA12 = 1'b1; BR_W = 1'b1; BA = 4'h0; SDRD = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; SSER = 1'b1;
      chk("rstd_data", data, 8'h00);
      chk("rstd_rdy", rdy, 0);
      chk("rstd_ovr", ovr, 0);
      chk("rstd_terr", terr, 0);
      chk("rstd_bitcnt", bitcnt, 0);
      repeat (3) @(negedge clk);
      send_byte(8'hFF);
      chk("ff_data", data, 8'hFF);
      chk("ff_rdy", rdy, 1);
      chk("ff_ovr", ovr, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
